// File: rtl/reg_writeback_ctrl_if.sv
// Retiring-instruction handshake between the MEM stage (master) and the
// write-back controller (slave).
interface reg_writeback_ctrl_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_rd;
    logic              in_reg_write;
    logic              in_mem_to_reg;
    logic [DATA_W-1:0] in_alu_result;
    logic [1:0]        in_load_size;
    logic              in_load_unsigned;
    logic [1:0]        in_byte_off;

    modport master (
        output in_valid, in_rd, in_reg_write, in_mem_to_reg, in_alu_result,
               in_load_size, in_load_unsigned, in_byte_off,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_rd, in_reg_write, in_mem_to_reg, in_alu_result,
               in_load_size, in_load_unsigned, in_byte_off,
        output in_ready
    );
endinterface

// File: rtl/reg_writeback_ctrl.sv
// MIPS register-file write-back controller: one single-cycle write per retired
// instruction, with load extraction and load timeout. Optional bypass outputs via WB_FORWARD_EN.
module reg_writeback_ctrl #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned LOAD_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    reg_writeback_ctrl_if.slave  up,
    input  logic                 mem_rdata_valid,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic [ADDR_W-1:0]    write,
    output logic [DATA_W-1:0]    write_data,
    output logic                 reg_write,
    output logic                 busy,
    output logic                 timeout_err
`ifdef WB_FORWARD_EN
    ,
    output logic                 fwd_valid,
    output logic [ADDR_W-1:0]    fwd_rd,
    output logic [DATA_W-1:0]    fwd_data
`endif
);
    localparam int unsigned CNT_W = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_MEM = 2'd1;
    localparam logic [1:0] COMMIT   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic              rw_q, rw_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        off_q, off_d;
    logic [ADDR_W-1:0] write_q, write_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic              reg_write_q, reg_write_d;
    logic              busy_q, busy_d;
    logic              in_ready_q, in_ready_d;
    logic              timeout_err_q, timeout_err_d;

    logic [7:0]        byte_lane_c;
    logic [15:0]       half_lane_c;
    logic [DATA_W-1:0] load_val_c;

    // Lane select and extension of the returning memory word
    always_comb begin
        byte_lane_c = mem_rdata[{off_q, 3'b000} +: 8];
        half_lane_c = mem_rdata[{off_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b01:   load_val_c = {{(DATA_W-16){~uns_q & half_lane_c[15]}}, half_lane_c};
            2'b10:   load_val_c = {{(DATA_W-8){~uns_q & byte_lane_c[7]}}, byte_lane_c};
            default: load_val_c = mem_rdata;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rd_d          = rd_q;
        rw_d          = rw_q;
        size_d        = size_q;
        uns_d         = uns_q;
        off_d         = off_q;
        write_d       = write_q;
        write_data_d  = write_data_q;
        reg_write_d   = 1'b0;
        timeout_err_d = timeout_err_q;

        case (state_q)
            IDLE: begin
                if (up.in_valid) begin
                    rd_d   = up.in_rd;
                    rw_d   = up.in_reg_write;
                    size_d = up.in_load_size;
                    uns_d  = up.in_load_unsigned;
                    off_d  = up.in_byte_off;
                    if (up.in_mem_to_reg) begin
                        state_d = WAIT_MEM;
                        cnt_d   = '0;
                    end else begin
                        state_d = COMMIT;
                        // ALU result is final at accept, so the write is staged here
                        if (up.in_reg_write && (up.in_rd != '0)) begin
                            reg_write_d  = 1'b1;
                            write_d      = up.in_rd;
                            write_data_d = up.in_alu_result;
                        end
                    end
                end
            end
            WAIT_MEM: begin
                // Data arriving on the limit cycle takes priority over the abort
                if (mem_rdata_valid) begin
                    state_d = COMMIT;
                    if (rw_q && (rd_q != '0)) begin
                        reg_write_d  = 1'b1;
                        write_d      = rd_q;
                        write_data_d = load_val_c;
                    end
                end else if (cnt_q == CNT_W'(LOAD_TIMEOUT - 1)) begin
                    state_d       = IDLE;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rd_q          <= '0;
            rw_q          <= 1'b0;
            size_q        <= 2'b00;
            uns_q         <= 1'b0;
            off_q         <= 2'b00;
            write_q       <= '0;
            write_data_q  <= '0;
            reg_write_q   <= 1'b0;
            busy_q        <= 1'b0;
            in_ready_q    <= 1'b1;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rd_q          <= rd_d;
            rw_q          <= rw_d;
            size_q        <= size_d;
            uns_q         <= uns_d;
            off_q         <= off_d;
            write_q       <= write_d;
            write_data_q  <= write_data_d;
            reg_write_q   <= reg_write_d;
            busy_q        <= busy_d;
            in_ready_q    <= in_ready_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign up.in_ready   = in_ready_q;
    assign write         = write_q;
    assign write_data    = write_data_q;
    assign reg_write     = reg_write_q;
    assign busy          = busy_q;
    assign timeout_err   = timeout_err_q;

`ifdef WB_FORWARD_EN
    // Bypass copy of the write that is landing this cycle
    assign fwd_valid = reg_write_q;
    assign fwd_rd    = write_q;
    assign fwd_data  = write_data_q;
`endif
endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Bench for reg_writeback_ctrl: directed vector table, multi-cycle corner
// sequences and randomized transactions against a rule-level model.
module tb_reg_writeback_ctrl;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned LT = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_rdata_valid;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] write;
    logic [DW-1:0] write_data;
    logic          reg_write;
    logic          busy;
    logic          timeout_err;
`ifdef WB_FORWARD_EN
    logic          fwd_valid;
    logic [AW-1:0] fwd_rd;
    logic [DW-1:0] fwd_data;
`endif

    always #5 clk = ~clk;

    reg_writeback_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    reg_writeback_ctrl #(.DATA_W(DW), .ADDR_W(AW), .LOAD_TIMEOUT(LT)) dut (
        .clk             (clk),
        .rst             (rst),
        .up              (bus),
        .mem_rdata_valid (mem_rdata_valid),
        .mem_rdata       (mem_rdata),
        .write           (write),
        .write_data      (write_data),
        .reg_write       (reg_write),
        .busy            (busy),
        .timeout_err     (timeout_err)
`ifdef WB_FORWARD_EN
        ,
        .fwd_valid       (fwd_valid),
        .fwd_rd          (fwd_rd),
        .fwd_data        (fwd_data)
`endif
    );

    typedef struct {
        logic        is_load;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] alu;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  off;
        logic [31:0] mem;
        int          delay;
        logic        exp_we;
        logic [31:0] exp_data;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    logic [4:0]  held_wr = 5'd0;
    logic [31:0] held_wd = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Register-file result of a load, straight from the extraction rules
    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                               input logic [1:0] off, input logic [31:0] mem);
        logic [31:0] lane;
        int          bits;
        if (size == 2'b01) begin
            bits = 16;
            lane = (mem >> (16 * int'(off[1]))) & 32'h0000_FFFF;
        end else if (size == 2'b10) begin
            bits = 8;
            lane = (mem >> (8 * int'(off))) & 32'h0000_00FF;
        end else begin
            return mem;
        end
        if (!uns && lane >= (32'd1 << (bits - 1))) lane = lane - (32'd1 << bits);
        return lane;
    endfunction

    function automatic vec_t mk(input logic is_load, input logic [4:0] rd, input logic rw,
                                input logic [31:0] alu, input logic [1:0] size, input logic uns,
                                input logic [1:0] off, input logic [31:0] mem, input int delay,
                                input logic exp_we, input logic [31:0] exp_data);
        vec_t v;
        v.is_load = is_load; v.rd = rd; v.rw = rw; v.alu = alu; v.size = size; v.uns = uns;
        v.off = off; v.mem = mem; v.delay = delay; v.exp_we = exp_we; v.exp_data = exp_data;
        return v;
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        check({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic drive_accept(input vec_t v);
        bus.in_valid         = 1'b1;
        bus.in_rd            = v.rd;
        bus.in_reg_write     = v.rw;
        bus.in_mem_to_reg    = v.is_load;
        bus.in_alu_result    = v.alu;
        bus.in_load_size     = v.size;
        bus.in_load_unsigned = v.uns;
        bus.in_byte_off      = v.off;
        step();
        bus.in_valid         = 1'b0;
    endtask

    // One instruction end to end; expectation supplied by the caller
    task automatic run_txn(input vec_t v, input string tag, input logic exp_we, input logic [31:0] exp_data);
        wait_ready(tag);
        drive_accept(v);
        if (v.is_load) begin
            for (int k = 0; k < v.delay; k++) begin
                check({tag, "_wait_rw"}, 32'(reg_write), 32'd0);
                step();
            end
            mem_rdata       = v.mem;
            mem_rdata_valid = 1'b1;
            step();
            mem_rdata_valid = 1'b0;
            mem_rdata       = $urandom;
        end
        check({tag, "_we"}, 32'(reg_write), 32'(exp_we));
        if (exp_we) begin
            held_wr = v.rd;
            held_wd = exp_data;
        end
        check({tag, "_wr"}, 32'(write), 32'(held_wr));
        check({tag, "_wd"}, write_data, held_wd);
`ifdef WB_FORWARD_EN
        check({tag, "_fwdv"}, 32'(fwd_valid), 32'(exp_we));
        if (exp_we) begin
            check({tag, "_fwdrd"}, 32'(fwd_rd), 32'(v.rd));
            check({tag, "_fwdd"}, fwd_data, exp_data);
        end
`endif
        step();
        check({tag, "_post_rw"}, 32'(reg_write), 32'd0);
        check({tag, "_post_rdy"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_hold_wr"}, 32'(write), 32'(held_wr));
        check({tag, "_hold_wd"}, write_data, held_wd);
    endtask

    vec_t tbl[13];

    initial begin
        vec_t v;
        logic [31:0] ed;
        logic        ew;

        tbl[0]  = mk(1'b0, 5'd5,  1'b1, 32'h1234_5678, 2'b00, 1'b0, 2'd0, 32'h0,         0,  1'b1, 32'h1234_5678);
        tbl[1]  = mk(1'b0, 5'd0,  1'b1, 32'hFFFF_FFFF, 2'b00, 1'b0, 2'd0, 32'h0,         0,  1'b0, 32'h0);
        tbl[2]  = mk(1'b1, 5'd8,  1'b1, 32'h0,         2'b10, 1'b0, 2'd2, 32'h0080_0000, 3,  1'b1, 32'hFFFF_FF80);
        tbl[3]  = mk(1'b1, 5'd8,  1'b1, 32'h0,         2'b10, 1'b1, 2'd2, 32'h0080_0000, 3,  1'b1, 32'h0000_0080);
        tbl[4]  = mk(1'b1, 5'd9,  1'b1, 32'h0,         2'b01, 1'b0, 2'd2, 32'h8001_7FFF, 1,  1'b1, 32'hFFFF_8001);
        tbl[5]  = mk(1'b1, 5'd9,  1'b1, 32'h0,         2'b00, 1'b0, 2'd2, 32'h8001_7FFF, 0,  1'b1, 32'h8001_7FFF);
        tbl[6]  = mk(1'b1, 5'd10, 1'b1, 32'h0,         2'b01, 1'b1, 2'd0, 32'h8001_7FFF, 2,  1'b1, 32'h0000_7FFF);
        tbl[7]  = mk(1'b1, 5'd11, 1'b1, 32'h0,         2'b01, 1'b0, 2'd3, 32'h8001_7FFF, 0,  1'b1, 32'hFFFF_8001);
        tbl[8]  = mk(1'b1, 5'd12, 1'b1, 32'h0,         2'b11, 1'b0, 2'd1, 32'hDEAD_BEEF, 4,  1'b1, 32'hDEAD_BEEF);
        tbl[9]  = mk(1'b1, 5'd13, 1'b1, 32'h0,         2'b10, 1'b0, 2'd0, 32'h0000_007F, 0,  1'b1, 32'h0000_007F);
        tbl[10] = mk(1'b0, 5'd12, 1'b0, 32'hAAAA_5555, 2'b00, 1'b0, 2'd0, 32'h0,         0,  1'b0, 32'h0);
        tbl[11] = mk(1'b1, 5'd31, 1'b1, 32'h0,         2'b10, 1'b0, 2'd3, 32'h9A00_0000, 14, 1'b1, 32'hFFFF_FF9A);
        tbl[12] = mk(1'b1, 5'd0,  1'b1, 32'h0,         2'b00, 1'b0, 2'd0, 32'h7777_7777, 2,  1'b0, 32'h0);

        rst = 1'b1;
        mem_rdata_valid = 1'b0;
        mem_rdata = '0;
        bus.in_valid = 1'b0;
        bus.in_rd = '0;
        bus.in_reg_write = 1'b0;
        bus.in_mem_to_reg = 1'b0;
        bus.in_alu_result = '0;
        bus.in_load_size = 2'b00;
        bus.in_load_unsigned = 1'b0;
        bus.in_byte_off = 2'b00;
        step();
        step();
        rst = 1'b0;
        check("rst_rw",    32'(reg_write),     32'd0);
        check("rst_wr",    32'(write),         32'd0);
        check("rst_wd",    write_data,         32'd0);
        check("rst_busy",  32'(busy),          32'd0);
        check("rst_rdy",   32'(bus.in_ready),  32'd1);
        check("rst_terr",  32'(timeout_err),   32'd0);
`ifdef WB_FORWARD_EN
        check("rst_fwdv",  32'(fwd_valid),     32'd0);
`endif

        for (int i = 0; i < 13; i++)
            run_txn(tbl[i], $sformatf("vec%0d", i), tbl[i].exp_we, tbl[i].exp_data);

        // New instruction held by upstream while the controller waits on a load
        v = mk(1'b1, 5'd7, 1'b1, 32'h0, 2'b10, 1'b1, 2'd1, 32'h0, 0, 1'b1, 32'h0);
        wait_ready("busy");
        drive_accept(v);
        bus.in_valid = 1'b1;
        bus.in_rd = 5'd9;
        bus.in_reg_write = 1'b1;
        bus.in_mem_to_reg = 1'b0;
        bus.in_alu_result = 32'hCAFE_F00D;
        for (int k = 0; k < 2; k++) begin
            check("busy_rdy",  32'(bus.in_ready), 32'd0);
            check("busy_busy", 32'(busy),         32'd1);
            check("busy_rw",   32'(reg_write),    32'd0);
            step();
        end
        mem_rdata = 32'h0000_AB00;
        mem_rdata_valid = 1'b1;
        step();
        mem_rdata_valid = 1'b0;
        check("busy_ld_we", 32'(reg_write), 32'd1);
        check("busy_ld_wr", 32'(write),     32'd7);
        check("busy_ld_wd", write_data,     32'h0000_00AB);
        step();
        check("busy_gap_rw", 32'(reg_write), 32'd0);
        step();
        bus.in_valid = 1'b0;
        check("busy_alu_we", 32'(reg_write), 32'd1);
        check("busy_alu_wr", 32'(write),     32'd9);
        check("busy_alu_wd", write_data,     32'hCAFE_F00D);
        held_wr = 5'd9;
        held_wd = 32'hCAFE_F00D;
        step();

        // Randomized instructions against the model, with stray data pulses while idle
        for (int i = 0; i < 40; i++) begin
            v.is_load = 1'($urandom_range(0, 1));
            v.rd      = 5'($urandom_range(0, 31));
            v.rw      = ($urandom_range(0, 3) != 0);
            v.alu     = $urandom;
            v.size    = 2'($urandom_range(0, 3));
            v.uns     = 1'($urandom_range(0, 1));
            v.off     = 2'($urandom_range(0, 3));
            v.mem     = $urandom;
            v.delay   = $urandom_range(0, LT - 1);
            if ($urandom_range(0, 3) == 0) begin
                mem_rdata_valid = 1'b1;
                step();
                mem_rdata_valid = 1'b0;
                check($sformatf("rnd%0d_stray_rw", i), 32'(reg_write), 32'd0);
                check($sformatf("rnd%0d_stray_busy", i), 32'(busy), 32'd0);
            end
            ew = v.rw && (v.rd != 5'd0);
            ed = v.is_load ? model_load(v.size, v.uns, v.off, v.mem) : v.alu;
            run_txn(v, $sformatf("rnd%0d", i), ew, ed);
        end

        // Reset while waiting on a load, data arriving right after
        v = mk(1'b1, 5'd4, 1'b1, 32'h0, 2'b00, 1'b0, 2'd0, 32'h0, 0, 1'b1, 32'h0);
        wait_ready("rstw");
        drive_accept(v);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        mem_rdata = 32'h1122_3344;
        mem_rdata_valid = 1'b1;
        check("rstw_rw0", 32'(reg_write), 32'd0);
        step();
        mem_rdata_valid = 1'b0;
        held_wr = 5'd0;
        held_wd = 32'd0;
        check("rstw_rw",   32'(reg_write),    32'd0);
        check("rstw_wr",   32'(write),        32'd0);
        check("rstw_wd",   write_data,        32'd0);
        check("rstw_busy", 32'(busy),         32'd0);
        check("rstw_rdy",  32'(bus.in_ready), 32'd1);
        check("rstw_terr", 32'(timeout_err),  32'd0);
        step();
        check("rstw_rw2",  32'(reg_write),    32'd0);

        // Load that never sees data: abort after LT cycles in the wait state
        v = mk(1'b1, 5'd3, 1'b1, 32'h0, 2'b00, 1'b0, 2'd0, 32'h0, 0, 1'b1, 32'h0);
        wait_ready("tmo");
        drive_accept(v);
        for (int k = 0; k < int'(LT); k++) begin
            check($sformatf("tmo_c%0d_rw", k),   32'(reg_write),   32'd0);
            check($sformatf("tmo_c%0d_busy", k), 32'(busy),        32'd1);
            check($sformatf("tmo_c%0d_terr", k), 32'(timeout_err), 32'd0);
            step();
        end
        check("tmo_terr", 32'(timeout_err),  32'd1);
        check("tmo_busy", 32'(busy),         32'd0);
        check("tmo_rdy",  32'(bus.in_ready), 32'd1);
        check("tmo_rw",   32'(reg_write),    32'd0);
        mem_rdata_valid = 1'b1;
        step();
        mem_rdata_valid = 1'b0;
        check("tmo_late_rw",   32'(reg_write), 32'd0);
        check("tmo_late_busy", 32'(busy),      32'd0);
        step();
        check("tmo_sticky", 32'(timeout_err), 32'd1);
        check("tmo_wr_keep", 32'(write),      32'(held_wr));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("tmo_rst_terr", 32'(timeout_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
